mc_controller: RTL and testbench
================================

MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port op  input  6  instruction opcode field (instr[31:26]).
REQ-004 SHALL have port funct  input  6  instruction funct field (instr[5:0]).
REQ-005 SHALL have port zero  input  1  ALU zero flag, high when aluout == 0.
REQ-006 SHALL have port alucontrol  output  3  ALU op: 000 AND, 001 OR, 010 ADD, 011 unused/zero, 100 AND~B, 101 OR~B, 110 SUB, 111 SLT.
REQ-007 SHALL have ports pcen, memwrite, irwrite, regwrite  output  1 each  PC, memory, instruction-register and register-file write enables.
REQ-008 SHALL have ports iord, memtoreg, regdst, alusrca  output  1 each  datapath muxes: 1 selects ALUOut address, memory data, rd, register A respectively.
REQ-009 SHALL have ports alusrcb, pcsrc  output  2 each  alusrcb: 00 B, 01 const 4, 10 signimm, 11 signimm<<2; pcsrc: 00 ALU result, 01 ALUOut, 10 jump target.
REQ-010 SHALL have port state  output  4  current FSM state code (debug/verification).

Function
REQ-011 SHALL be a Moore FSM, one state per cycle; state codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11.
REQ-012 SHALL default every control output to 0 in any state not asserting it.
REQ-013 FETCH SHALL assert iord=0, irwrite=1, alusrca=0, alusrcb=01, alucontrol=010, pcsrc=00, pcen=1; next DECODE.
REQ-014 DECODE SHALL drive alusrca=0, alusrcb=11, alucontrol=010 (branch target precompute); next by op: 100011/101011 MEMADR, 000000 EXECUTE, 000100 BRANCH, 001000 ADDIEX, 000010 JUMP, any other FETCH.
REQ-015 MEMADR SHALL drive alusrca=1, alusrcb=10, alucontrol=010; next MEMRD if op=100011, else MEMWR.
REQ-016 MEMRD SHALL drive iord=1, next MEMWB; MEMWB SHALL drive regwrite=1, memtoreg=1, regdst=0, next FETCH.
REQ-017 MEMWR SHALL drive iord=1, memwrite=1; next FETCH.
REQ-018 EXECUTE SHALL drive alusrca=1, alusrcb=00, alucontrol from funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111, other->011; next ALUWB.
REQ-019 ALUWB SHALL drive regwrite=1, regdst=1, memtoreg=0; next FETCH.
REQ-020 BRANCH SHALL drive alusrca=1, alusrcb=00, alucontrol=110, pcsrc=01, pcen=zero (same cycle, combinational on zero); next FETCH.
REQ-021 ADDIEX SHALL drive alusrca=1, alusrcb=10, alucontrol=010, next ADDIWB; ADDIWB SHALL drive regwrite=1, regdst=0, memtoreg=0, next FETCH.
REQ-022 JUMP SHALL drive pcsrc=10, pcen=1; next FETCH.
REQ-023 Instruction latencies SHALL be: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles; unknown op 2 cycles (no write besides FETCH's PC/IR).
REQ-024 Unused state codes 12-15 SHALL drive all outputs 0 and transition to FETCH.

Reset
REQ-025 reset high at a rising edge SHALL load state=FETCH regardless of current state, including mid-instruction.
REQ-026 While reset is high, pcen, memwrite, irwrite, regwrite SHALL be forced 0 combinationally; other outputs follow state.
REQ-027 After reset deasserts, the first cycle SHALL be FETCH with outputs per REQ-013.

Configuration
REQ-028 Macro MC_CONTROLLER_BNE_EN defined SHALL decode op=000101 in DECODE to BRANCH, with pcen=~zero there for bne and pcen=zero for beq (op latched by datapath IR, stable through BRANCH).
REQ-029 Without MC_CONTROLLER_BNE_EN, op=000101 SHALL be treated as unknown (DECODE->FETCH).

Verification
REQ-030 reset high 2 cycles mid-MEMRD -> state=0 next edge, no write enable high during reset; release -> state sequence 0,1.
REQ-031 op=100011 -> states 0,1,2,3,4,0; regwrite=1,memtoreg=1 only in state 4; memwrite never high.
REQ-032 op=000000, funct=101010 -> states 0,1,6,7,0; alucontrol=111 in 6; regwrite=1,regdst=1 in 7.
REQ-033 op=000100 with zero=1 in BRANCH -> pcen=1,pcsrc=01; repeat with zero=0 -> pcen=0; both return to FETCH.
REQ-034 op=000101 zero=0: with MC_CONTROLLER_BNE_EN -> states 0,1,8, pcen=1; without -> states 0,1,0, pcen=0 in DECODE.
REQ-035 op=101011 -> states 0,1,2,5,0, memwrite=1 and iord=1 only in 5; op=000010 -> states 0,1,11,0 with pcsrc=10, pcen=1 in 11.

Source files
------------

// File: rtl/mc_controller.sv
// Multicycle MIPS-subset main controller: Moore FSM that sequences fetch/decode/execute steps.
// Optional bne support is compiled in when MC_CONTROLLER_BNE_EN is defined.
module mc_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic [2:0] alucontrol,
    output logic       pcen,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAdr  = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StExecute = 4'd6,
        StAluWb   = 4'd7,
        StBranch  = 4'd8,
        StAddiEx  = 4'd9,
        StAddiWb  = 4'd10,
        StJump    = 4'd11
    } state_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpJ     = 6'b000010;
`ifdef MC_CONTROLLER_BNE_EN
    localparam logic [5:0] OpBne   = 6'b000101;
`endif

    localparam logic [2:0] AluAnd = 3'b000;
    localparam logic [2:0] AluOr  = 3'b001;
    localparam logic [2:0] AluAdd = 3'b010;
    localparam logic [2:0] AluNop = 3'b011;
    localparam logic [2:0] AluSub = 3'b110;
    localparam logic [2:0] AluSlt = 3'b111;

    typedef struct packed {
        logic [2:0] alu;
        logic       pcen;
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic       iord;
        logic       memtoreg;
        logic       regdst;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic       branch;
    } ctrl_t;

    state_e state_q, state_d;
    ctrl_t  ctrl_q;
    logic   branch_taken;
    logic   pcen_raw;

    // Moore decode of a state into its control word; anything not listed stays 0.
    function automatic ctrl_t ctrl_for(state_e s);
        ctrl_t c;
        c = '0;
        case (s)
            StFetch: begin
                c.irwrite = 1'b1;
                c.alusrcb = 2'b01;
                c.alu     = AluAdd;
                c.pcen    = 1'b1;
            end
            StDecode: begin
                c.alusrcb = 2'b11;
                c.alu     = AluAdd;
            end
            StMemAdr: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
                c.alu     = AluAdd;
            end
            StMemRd: c.iord = 1'b1;
            StMemWb: begin
                c.regwrite = 1'b1;
                c.memtoreg = 1'b1;
            end
            StMemWr: begin
                c.iord     = 1'b1;
                c.memwrite = 1'b1;
            end
            StExecute: c.alusrca = 1'b1;
            StAluWb: begin
                c.regwrite = 1'b1;
                c.regdst   = 1'b1;
            end
            StBranch: begin
                c.alusrca = 1'b1;
                c.alu     = AluSub;
                c.pcsrc   = 2'b01;
                c.branch  = 1'b1;
            end
            StAddiEx: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
                c.alu     = AluAdd;
            end
            StAddiWb: c.regwrite = 1'b1;
            StJump: begin
                c.pcsrc = 2'b10;
                c.pcen  = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic [2:0] funct_alu(logic [5:0] f);
        case (f)
            6'b100000: return AluAdd;
            6'b100010: return AluSub;
            6'b100100: return AluAnd;
            6'b100101: return AluOr;
            6'b101010: return AluSlt;
            default:   return AluNop;
        endcase
    endfunction

    always_comb begin
        state_d = StFetch;
        case (state_q)
            StFetch:  state_d = StDecode;
            StDecode: begin
                case (op)
                    OpLw, OpSw: state_d = StMemAdr;
                    OpRtype:    state_d = StExecute;
                    OpBeq:      state_d = StBranch;
`ifdef MC_CONTROLLER_BNE_EN
                    OpBne:      state_d = StBranch;
`endif
                    OpAddi:     state_d = StAddiEx;
                    OpJ:        state_d = StJump;
                    default:    state_d = StFetch;
                endcase
            end
            StMemAdr:  state_d = (op == OpLw) ? StMemRd : StMemWr;
            StMemRd:   state_d = StMemWb;
            StExecute: state_d = StAluWb;
            StAddiEx:  state_d = StAddiWb;
            default:   state_d = StFetch;
        endcase
    end

    // Control word is registered alongside the state so outputs come straight from flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
            ctrl_q  <= ctrl_for(StFetch);
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_for(state_d);
        end
    end

    always_comb begin
`ifdef MC_CONTROLLER_BNE_EN
        branch_taken = (op == OpBne) ? ~zero : zero;
`else
        branch_taken = zero;
`endif
        pcen_raw = ctrl_q.branch ? branch_taken : ctrl_q.pcen;
    end

    // funct and zero act within the current cycle, so they bypass the registered word.
    assign alucontrol = (state_q == StExecute) ? funct_alu(funct) : ctrl_q.alu;
    assign pcen       = pcen_raw & ~reset;
    assign memwrite   = ctrl_q.memwrite & ~reset;
    assign irwrite    = ctrl_q.irwrite & ~reset;
    assign regwrite   = ctrl_q.regwrite & ~reset;
    assign iord       = ctrl_q.iord;
    assign memtoreg   = ctrl_q.memtoreg;
    assign regdst     = ctrl_q.regdst;
    assign alusrca    = ctrl_q.alusrca;
    assign alusrcb    = ctrl_q.alusrcb;
    assign pcsrc      = ctrl_q.pcsrc;
    assign state      = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: per-instruction state paths and output table model.
module tb_mc_controller;
    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic [2:0] alucontrol;
    logic       pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    logic [18:0] exp_q[$];
    int          path[$];

    mc_controller dut (
        .clk       (clk),
        .reset     (reset),
        .op        (op),
        .funct     (funct),
        .zero      (zero),
        .alucontrol(alucontrol),
        .pcen      (pcen),
        .memwrite  (memwrite),
        .irwrite   (irwrite),
        .regwrite  (regwrite),
        .iord      (iord),
        .memtoreg  (memtoreg),
        .regdst    (regdst),
        .alusrca   (alusrca),
        .alusrcb   (alusrcb),
        .pcsrc     (pcsrc),
        .state     (state)
    );

    always #5 clk = ~clk;

    // Whole state visit list of one instruction, from its FETCH onwards.
    function automatic void set_path(input logic [5:0] o);
        path.delete();
        case (o)
            6'b100011: path = '{0, 1, 2, 3, 4};
            6'b101011: path = '{0, 1, 2, 5};
            6'b000000: path = '{0, 1, 6, 7};
            6'b001000: path = '{0, 1, 9, 10};
            6'b000100: path = '{0, 1, 8};
            6'b000010: path = '{0, 1, 11};
`ifdef MC_CONTROLLER_BNE_EN
            6'b000101: path = '{0, 1, 8};
`endif
            default:   path = '{0, 1};
        endcase
    endfunction

    // {state, alucontrol, pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca,
    //  alusrcb, pcsrc}
    function automatic logic [18:0] exp_vec(input int st, input logic [5:0] o,
                                            input logic [5:0] f, input logic z,
                                            input logic rst);
        logic [2:0] alu = 3'b000;
        logic pe = 0, mw = 0, iw = 0, rw = 0, io = 0, mr = 0, rd = 0, sa = 0;
        logic [1:0] sb = 2'b00, ps = 2'b00;
        case (st)
            0: begin alu = 3'b010; pe = 1; iw = 1; sb = 2'b01; end
            1: begin alu = 3'b010; sb = 2'b11; end
            2: begin alu = 3'b010; sa = 1; sb = 2'b10; end
            3: io = 1;
            4: begin rw = 1; mr = 1; end
            5: begin io = 1; mw = 1; end
            6: begin
                sa = 1;
                if (f == 6'b100000) alu = 3'b010;
                else if (f == 6'b100010) alu = 3'b110;
                else if (f == 6'b100100) alu = 3'b000;
                else if (f == 6'b100101) alu = 3'b001;
                else if (f == 6'b101010) alu = 3'b111;
                else alu = 3'b011;
            end
            7: begin rw = 1; rd = 1; end
            8: begin
                sa = 1; alu = 3'b110; ps = 2'b01; pe = z;
`ifdef MC_CONTROLLER_BNE_EN
                if (o == 6'b000101) pe = ~z;
`endif
            end
            9: begin alu = 3'b010; sa = 1; sb = 2'b10; end
            10: rw = 1;
            11: begin ps = 2'b10; pe = 1; end
            default: ;
        endcase
        if (rst) begin pe = 0; mw = 0; iw = 0; rw = 0; end
        return {st[3:0], alu, pe, mw, iw, rw, io, mr, rd, sa, sb, ps};
    endfunction

    // Monitor: every cycle the DUT presents its outputs, compare against the oldest expectation.
    always @(negedge clk) begin
        logic [18:0] e, a;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            a = {state, alucontrol, pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst,
                 alusrca, alusrcb, pcsrc};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL ctrl t=%0t op=%b funct=%b zero=%b reset=%b act=%h exp=%h (state act=%0d exp=%0d)",
                         $time, op, funct, zero, reset, a, e, a[18:15], e[18:15]);
            end
        end
    end

    initial begin
        logic [5:0] dir_ops[9];
        logic [5:0] known[8];
        logic [5:0] cur_op, cur_fn;
        logic       r;
        int         idx, rst_cnt, n_instr;
        bit         dir_done;
        dir_ops = '{6'b100011, 6'b000000, 6'b000100, 6'b000100, 6'b000101, 6'b101011,
                    6'b000010, 6'b001000, 6'b111111};
        known   = '{6'b100011, 6'b101011, 6'b000000, 6'b001000, 6'b000100, 6'b000010,
                    6'b000101, 6'b000000};
        reset = 1'b1; op = 6'd0; funct = 6'd0; zero = 1'b0;
        cur_op = 6'd0; cur_fn = 6'b101010;
        @(posedge clk);
        @(posedge clk);
        idx = 0; rst_cnt = 1; n_instr = 0; dir_done = 0;
        set_path(cur_op);
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(posedge clk);
            #1;
            if (idx == 0) begin
                if (n_instr < 9) cur_op = dir_ops[n_instr];
                else if ($urandom_range(0, 4) == 0) cur_op = 6'($urandom);
                else cur_op = known[$urandom_range(0, 7)];
                if (n_instr == 1) cur_fn = 6'b101010;
                else if ($urandom_range(0, 5) == 0) cur_fn = 6'($urandom);
                else begin
                    case ($urandom_range(0, 4))
                        0: cur_fn = 6'b100000;
                        1: cur_fn = 6'b100010;
                        2: cur_fn = 6'b100100;
                        3: cur_fn = 6'b100101;
                        default: cur_fn = 6'b101010;
                    endcase
                end
                n_instr++;
                set_path(cur_op);
            end
            zero = 1'($urandom);
            if (path[idx] == 8 && n_instr == 3) zero = 1'b1;
            if (path[idx] == 8 && (n_instr == 4 || n_instr == 5)) zero = 1'b0;
            if (!dir_done && path[idx] == 3) begin
                rst_cnt = 2;
                dir_done = 1;
            end else if (rst_cnt == 0 && n_instr > 9 && $urandom_range(0, 59) == 0) begin
                rst_cnt = $urandom_range(1, 2);
            end
            r = (rst_cnt > 0);
            if (rst_cnt > 0) rst_cnt--;
            op = cur_op; funct = cur_fn; reset = r;
            exp_q.push_back(exp_vec(path[idx], cur_op, cur_fn, zero, r));
            if (r) idx = 0;
            else begin
                idx++;
                if (idx == path.size()) idx = 0;
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
